rle_pair_feeder: RTL and testbench



---
 rtl/rle_feeder_pkg.sv | 15 +
 rtl/rle_pair_feeder_if.sv | 22 ++
 rtl/rle_bit_buffer.sv | 40 ++++
 rtl/rle_pair_feeder.sv | 93 +++++++++
 tb/tb_rle_pair_feeder.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/rle_feeder_pkg.sv
// Shared widths and FSM encoding for the run-length decompressor's pair feeder.
package rle_feeder_pkg;
    localparam int WORD_W = 16;
    localparam int CODE_W = 3;
    localparam int PAIR_W = 2 * CODE_W;
    localparam int BUF_W  = WORD_W + PAIR_W - 1;
    localparam int CNT_W  = 16;
    localparam int HELD_W = $clog2(BUF_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;
endpackage

// File: rtl/rle_pair_feeder_if.sv
// Word input stream and code-pair output stream of the pair feeder.
interface rle_pair_feeder_if;
    import rle_feeder_pkg::*;

    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;
    logic [CODE_W-1:0] in1;
    logic [CODE_W-1:0] in2;
    logic              pair_valid;
    logic              pair_ready;

    modport master (
        output word_in, word_valid, pair_ready,
        input  word_ready, in1, in2, pair_valid
    );

    modport slave (
        input  word_in, word_valid, pair_ready,
        output word_ready, in1, in2, pair_valid
    );
endinterface

// File: rtl/rle_bit_buffer.sv
// Left-aligned bit accumulator: words are appended just below the held bits,
// pairs are taken from the top.
module rle_bit_buffer
    import rle_feeder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [WORD_W-1:0] word,
    output logic [PAIR_W-1:0] head,
    output logic [HELD_W-1:0] held
);
    logic [BUF_W-1:0]  bits;
    logic [BUF_W-1:0]  word_ext;
    logic [HELD_W-1:0] shamt;

    // Push only happens with held < PAIR_W, so the shift never goes negative.
    assign shamt    = HELD_W'(BUF_W - WORD_W) - held;
    assign word_ext = BUF_W'(word) << shamt;
    assign head     = bits[BUF_W-1 -: PAIR_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits <= '0;
            held <= '0;
        end else if (clear) begin
            bits <= '0;
            held <= '0;
        end else if (push) begin
            bits <= bits | word_ext;
            held <= held + HELD_W'(WORD_W);
        end else if (pop) begin
            // Zero fill keeps the unused tail clean for the OR-append.
            bits <= bits << PAIR_W;
            held <= held - HELD_W'(PAIR_W);
        end
    end
endmodule

// File: rtl/rle_pair_feeder.sv
// Pair feeder: slices compressed words into {in1,in2} code pairs, counts the
// stream length, drops tail padding and pulses stream_done.
module rle_pair_feeder
    import rle_feeder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  pair_count,
    rle_pair_feeder_if.slave  bus,
    output logic              busy,
    output logic              stream_done,
    output logic [HELD_W-1:0] bits_held
);
    state_t            state, state_nxt;
    logic [CNT_W-1:0]  pairs_to_load;
    logic              push, pop, clear, word_ready;
    logic              pair_valid;
    logic [CODE_W-1:0] in1, in2;
    logic [PAIR_W-1:0] head;

    assign bus.word_ready = word_ready;
    assign bus.pair_valid = pair_valid;
    assign bus.in1        = in1;
    assign bus.in2        = in2;

    rle_bit_buffer u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .word  (bus.word_in),
        .head  (head),
        .held  (bits_held)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        word_ready  = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        clear       = 1'b0;
        busy        = 1'b0;
        stream_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (pair_count == '0) ? FINISH : RUN;
            end
            RUN: begin
                busy       = 1'b1;
                word_ready = (bits_held < HELD_W'(PAIR_W)) && (pairs_to_load != '0);
                push       = word_ready && bus.word_valid;
                pop        = (bits_held >= HELD_W'(PAIR_W)) && (pairs_to_load != '0)
                             && (!pair_valid || bus.pair_ready);
                // Last pair leaving the output register ends the stream.
                if ((pairs_to_load == '0) && pair_valid && bus.pair_ready)
                    state_nxt = FINISH;
            end
            FINISH: begin
                stream_done = 1'b1;
                clear       = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pairs_to_load <= '0;
            pair_valid    <= 1'b0;
            in1           <= '0;
            in2           <= '0;
        end else begin
            if (state == IDLE && start) pairs_to_load <= pair_count;
            else if (pop)               pairs_to_load <= pairs_to_load - CNT_W'(1);

            if (pop) begin
                pair_valid <= 1'b1;
                in1        <= head[PAIR_W-1 -: CODE_W];
                in2        <= head[CODE_W-1:0];
            end else if (bus.pair_ready) begin
                pair_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rle_pair_feeder.sv
// Directed vector bench for rle_pair_feeder: table of streams plus reset cases.
module tb_rle_pair_feeder;
    import rle_feeder_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  pair_count = '0;
    logic              busy, stream_done;
    logic [HELD_W-1:0] bits_held;

    rle_pair_feeder_if bus();

    rle_pair_feeder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pair_count  (pair_count),
        .bus         (bus),
        .busy        (busy),
        .stream_done (stream_done),
        .bits_held   (bits_held)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int               pc;
        int               nwords;
        logic [2:0][15:0] words;
        int               npairs;
        logic [7:0][5:0]  pairs;
        int               stall;
        int               again;
        int               abort_at;
        int               first_pv;
        int               done_at;
    } vec_t;

    vec_t vecs[7];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " word_ready"}, 32'(bus.word_ready), 0);
        chk({tag, " pair_valid"}, 32'(bus.pair_valid), 0);
        chk({tag, " busy"},       32'(busy), 0);
        chk({tag, " stream_done"},32'(stream_done), 0);
        chk({tag, " in1"},        32'(bus.in1), 0);
        chk({tag, " in2"},        32'(bus.in2), 0);
        chk({tag, " bits_held"},  32'(bits_held), 0);
    endtask

    function automatic vec_t mk(int pc, int nw, logic [15:0] w0, logic [15:0] w1,
                                logic [15:0] w2, int np, int stall, int again,
                                int abort_at, int fpv, int dn);
        vec_t v;
        v          = '0;
        v.pc       = pc;
        v.nwords   = nw;
        v.words[0] = w0;
        v.words[1] = w1;
        v.words[2] = w2;
        v.npairs   = np;
        v.stall    = stall;
        v.again    = again;
        v.abort_at = abort_at;
        v.first_pv = fpv;
        v.done_at  = dn;
        return v;
    endfunction

    task automatic run_vec(input int id, input vec_t v);
        int   wi = 0, pi = 0, cyc = 0, stall_left = 0;
        int   done_at = -1, first_pv = -1, viol = 0;
        bit   seen_pv = 0, wr_seen = 0, stop = 0;
        @(negedge clk);
        start          = 1'b1;
        pair_count     = v.pc[CNT_W-1:0];
        bus.word_valid = 1'b0;
        bus.pair_ready = 1'b0;
        while (!stop && cyc < 200) begin
            @(negedge clk);
            start = (cyc == v.again);
            if (start) pair_count = 16'd5;
            if (bus.pair_valid && !seen_pv) begin
                seen_pv    = 1;
                first_pv   = cyc;
                stall_left = v.stall;
            end
            if (stall_left > 0) begin
                bus.pair_ready = 1'b0;
                stall_left--;
            end else begin
                bus.pair_ready = 1'b1;
            end
            bus.word_valid = (wi < v.nwords);
            bus.word_in    = (wi < v.nwords) ? v.words[wi] : 16'h0;
            #1;
            if (cyc == 0) chk($sformatf("v%0d busy_on_start", id), 32'(busy), 32'(v.pc != 0));
            if (bus.word_ready) wr_seen = 1;
            if (bus.word_ready && bits_held >= 5'd6) viol++;
            if (stream_done) begin
                done_at = cyc;
                stop    = 1;
            end else begin
                if (bus.word_valid && bus.word_ready) wi++;
                if (bus.pair_valid) begin
                    if (pi < v.npairs)
                        chk($sformatf("v%0d pair%0d", id, pi), 32'({bus.in1, bus.in2}),
                            32'(v.pairs[pi]));
                    else
                        chk($sformatf("v%0d extra_pair", id), pi, v.npairs - 1);
                    if (bus.pair_ready) begin
                        pi++;
                        if (v.abort_at != 0 && pi == v.abort_at) stop = 1;
                    end
                end
            end
            cyc++;
        end
        start = 1'b0;
        if (v.abort_at != 0) begin
            chk($sformatf("v%0d pairs_before_abort", id), pi, v.abort_at);
            return;
        end
        chk($sformatf("v%0d done_seen", id), 32'(done_at >= 0), 1);
        chk($sformatf("v%0d pairs", id), pi, v.npairs);
        chk($sformatf("v%0d words", id), wi, v.nwords);
        chk($sformatf("v%0d word_ready_seen", id), 32'(wr_seen), 32'(v.nwords > 0));
        chk($sformatf("v%0d ready_while_full", id), viol, 0);
        if (v.first_pv >= 0) chk($sformatf("v%0d first_pv_cycle", id), first_pv, v.first_pv);
        if (v.done_at >= 0)  chk($sformatf("v%0d done_cycle", id), done_at, v.done_at);
        bus.word_valid = 1'b0;
        @(negedge clk);
        #1;
        chk($sformatf("v%0d done_one_cycle", id), 32'(stream_done), 0);
        chk($sformatf("v%0d busy_after", id), 32'(busy), 0);
        chk($sformatf("v%0d held_after", id), 32'(bits_held), 0);
        chk($sformatf("v%0d word_ready_after", id), 32'(bus.word_ready), 0);
    endtask

    initial begin
        bus.word_in    = '0;
        bus.word_valid = 1'b0;
        bus.pair_ready = 1'b0;

        //           pc nw  w0        w1        w2       np st again ab fpv done
        vecs[0] = mk(3, 2, 16'h77B3, 16'h4000, 16'h0000, 3, 0, -1,  0, 2,  6);
        vecs[1] = mk(3, 2, 16'h77B3, 16'h4000, 16'h0000, 3, 5, -1,  0, 2, -1);
        vecs[2] = mk(8, 3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8, 0, -1,  0, 2, 12);
        vecs[3] = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, -1,  0, -1, 0);
        vecs[4] = mk(3, 2, 16'h77B3, 16'h4000, 16'h0000, 3, 0, -1,  2, -1, -1);
        vecs[5] = mk(1, 1, 16'hA000, 16'h0000, 16'h0000, 1, 0, -1,  0, 2,  3);
        vecs[6] = mk(3, 2, 16'h77B3, 16'h4000, 16'h0000, 3, 0,  3,  0, 2,  6);
        for (int k = 0; k < 7; k++) begin
            if (k != 2 && k != 3 && k != 5) begin
                vecs[k].pairs[0] = 6'b011_101;
                vecs[k].pairs[1] = 6'b111_011;
                vecs[k].pairs[2] = 6'b001_101;
            end
        end
        for (int p = 0; p < 8; p++) vecs[2].pairs[p] = 6'b111_111;
        vecs[5].pairs[0] = 6'b101_000;

        repeat (2) @(negedge clk);
        #1;
        chk_reset("por");
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) run_vec(k, vecs[k]);

        // vecs[4] stops right after its second pair; drop reset mid-stream.
        @(negedge clk);
        rst_n          = 1'b0;
        bus.word_valid = 1'b0;
        bus.pair_ready = 1'b0;
        #1;
        chk_reset("mid_rst");
        repeat (2) @(negedge clk);
        #1;
        chk_reset("mid_rst_hold");
        rst_n = 1'b1;

        for (int k = 5; k < 7; k++) run_vec(k, vecs[k]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
